alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath width in bits (legal 4..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width taken from Bin[SHW-1:0].
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when in_valid is also high.
REQ-007 SHALL have port Ain  input  WIDTH  operand A.
REQ-008 SHALL have port Bin  input  WIDTH  operand B.
REQ-009 SHALL have port ALUop  input  3  operation select.
REQ-010 SHALL have port ldstat  input  1  request updates status register on retirement.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out  output  WIDTH  result.
REQ-014 SHALL have ports Z, V, N  output  1 each  per-result flags travelling with out.
REQ-015 SHALL have port stat  output  3  status register {Z,V,N} of last retired ldstat request.

Function
REQ-016 SHALL be a two-stage elastic pipeline: S1 registers {Ain,Bin,ALUop,ldstat}; S2 registers {out,Z,V,N,ldstat}.
REQ-017 SHALL advance S2 when !s2_valid or out_ready; S1 moves to S2 when s1_valid and S2 advances.
REQ-018 SHALL drive in_ready = !s1_valid or S1 moves this cycle (combinational from out_ready allowed).
REQ-019 SHALL present a request accepted at edge k on out at edge k+2 when never stalled; throughput one per cycle.
REQ-020 SHALL hold out, Z, V, N, out_valid stable while out_valid && !out_ready.
REQ-021 SHALL compute ALUop: 000 A+B, 001 A-B, 010 A&B, 011 ~B, 100 A|B, 101 A^B, 110 A<<B[SHW-1:0], 111 A>>>B[SHW-1:0] (arithmetic).
REQ-022 SHALL wrap add/sub modulo 2^WIDTH; carry discarded.
REQ-023 SHALL set Z = (out==0), N = out[WIDTH-1] for every op.
REQ-024 SHALL set V for add when A,B signs equal and result sign differs; for sub when A,B signs differ and result sign differs from A; V=0 for all other ops.
REQ-025 SHALL load stat <= {Z,V,N} on the edge where out_valid && out_ready && s2 ldstat; otherwise hold.
REQ-026 SHALL, on simultaneous S2 retirement and S1 transfer, retire the old result and capture the new one in the same edge with no bubble.
REQ-027 SHALL ignore Ain/Bin/ALUop/ldstat when in_valid && in_ready is false.

Reset
REQ-028 SHALL, while reset high, force s1_valid=0, s2_valid=0, out_valid=0, out=0, Z=V=N=0, stat=3'b000, independent of clk.
REQ-029 SHALL discard all in-flight requests on reset mid-operation; none reappear after release.
REQ-030 SHALL assert in_ready in the first cycle after reset release.

Verification
REQ-031 WIDTH=16, out_ready=1: Ain=0x7FFF, Bin=0x0001, ALUop=000, ldstat=1 -> two edges later out=0x8000, Z=0, V=1, N=1; next edge stat=3'b011.
REQ-032 Back-to-back: 0x8000-0x0001 (001), then 0x000F-0x000F (001), then 0x0002-0x0001 (001) -> consecutive cycles out=0x7FFF V=1 N=0, out=0x0000 Z=1, out=0x0001 all flags 0.
REQ-033 Logic/shift: Ain=0x1000, Bin=0x0001 with 010, 011, 110, then Ain=0x8000 Bin=0x0004 with 111 -> 0x0000 Z=1, 0xFFFE N=1, 0x2000, 0xF800 N=1; V=0 throughout.
REQ-034 Backpressure: out_ready=0 for 5 cycles with 3 requests offered -> in_ready drops after 2 accepted, out frozen on first result; release -> results in order, none lost or duplicated.
REQ-035 ldstat=0 request retiring after ldstat=1 request -> stat unchanged from first; reset asserted with both stages full -> out_valid=0, stat=0 immediately, no stale output after release.
REQ-036 WIDTH=8: 0x7F+0x01 -> 0x80 V=1 N=1; 0x81<<3 (Bin=0x0B, uses low 3 bits) -> 0x08.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage elastic ALU pipeline: stage 1 holds the operands, stage 2 holds the result and its flags.
// The status register latches {Z,V,N} when a result that requested it is accepted downstream.
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   input  logic [2:0]       ALUop,
   input  logic             ldstat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             Z,
   output logic             V,
   output logic             N,
   output logic [2:0]       stat
);

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_op;
   logic             r_s1_ld;
   logic             r_s2_valid;
   logic             r_s2_ld;
   logic [WIDTH-1:0] r_out;
   logic             r_z;
   logic             r_v;
   logic             r_n;
   logic [2:0]       r_stat;

   logic             w_s2_adv;
   logic             w_s1_move;
   logic             w_accept;
   logic [WIDTH-1:0] w_res;
   logic             w_v;
   logic [SHW-1:0]   w_sh;

   // A full result stage frees itself only on retirement, so in_ready follows out_ready combinationally.
   assign w_s2_adv  = ~r_s2_valid | out_ready;
   assign w_s1_move = r_s1_valid & w_s2_adv;
   assign in_ready  = ~r_s1_valid | w_s1_move;
   assign w_accept  = in_valid & in_ready;
   assign w_sh      = r_s1_b[SHW-1:0];

   // ALU operation and signed-overflow flag on the stage-1 operands
   always_comb begin
      w_res = '0;
      w_v   = 1'b0;
      case (r_s1_op)
         3'b000: begin
            w_res = r_s1_a + r_s1_b;
            w_v   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         3'b001: begin
            w_res = r_s1_a - r_s1_b;
            w_v   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         3'b010:  w_res = r_s1_a & r_s1_b;
         3'b011:  w_res = ~r_s1_b;
         3'b100:  w_res = r_s1_a | r_s1_b;
         3'b101:  w_res = r_s1_a ^ r_s1_b;
         3'b110:  w_res = r_s1_a << w_sh;
         3'b111:  w_res = $unsigned($signed(r_s1_a) >>> w_sh);
         default: w_res = '0;
      endcase
   end

   // Operand stage: loads on an accepted request, empties when its contents move to stage 2
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= 3'b000;
         r_s1_ld    <= 1'b0;
      end else begin
         r_s1_valid <= w_accept | (r_s1_valid & ~w_s1_move);
         if (w_accept) begin
            r_s1_a  <= Ain;
            r_s1_b  <= Bin;
            r_s1_op <= ALUop;
            r_s1_ld <= ldstat;
         end
      end
   end

   // Result stage and status register; result holds while stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_s2_ld    <= 1'b0;
         r_out      <= '0;
         r_z        <= 1'b0;
         r_v        <= 1'b0;
         r_n        <= 1'b0;
         r_stat     <= 3'b000;
      end else begin
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out   <= w_res;
               r_z     <= (w_res == '0);
               r_v     <= w_v;
               r_n     <= w_res[WIDTH-1];
               r_s2_ld <= r_s1_ld;
            end
         end
         if (r_s2_valid & out_ready & r_s2_ld) begin
            r_stat <= {r_z, r_v, r_n};
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out       = r_out;
   assign Z         = r_z;
   assign V         = r_v;
   assign N         = r_n;
   assign stat      = r_stat;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 16-bit instance under directed and random traffic, plus an 8-bit instance.
module tb_alu_pipe;
   localparam int W = 16;

   typedef struct packed {
      logic [63:0] res;
      logic        z;
      logic        v;
      logic        n;
      logic        ld;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          in_valid, in_ready, ldstat, out_valid, out_ready, Z, V, N;
   logic [W-1:0]  Ain, Bin, out;
   logic [2:0]    ALUop, stat;
   logic          in_valid8, in_ready8, ldstat8, out_valid8, out_ready8, Z8, V8, N8;
   logic [7:0]    Ain8, Bin8, out8;
   logic [2:0]    ALUop8, stat8;

   exp_t          q[$];
   exp_t          q8[$];
   logic [2:0]    exp_stat;
   int            checks;
   int            errors;

   alu_pipe #(.WIDTH(W)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .ldstat(ldstat),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .Z(Z), .V(V), .N(N), .stat(stat)
   );

   alu_pipe #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .Ain(Ain8), .Bin(Bin8), .ALUop(ALUop8), .ldstat(ldstat8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
      .Z(Z8), .V(V8), .N(N8), .stat(stat8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference: operands as signed integers, overflow = true result outside the signed range.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] op, input logic ld);
      exp_t        e;
      longint      lim, sa, sb, r;
      logic [63:0] mask;
      int          sh;
      lim  = 64'sd1 <<< (w - 1);
      mask = (64'd1 << w) - 64'd1;
      sa   = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
      sb   = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
      sh   = int'(b % 64'(w));
      e.v  = 1'b0;
      case (op)
         3'd0: begin r = sa + sb; e.v = (r >= lim) || (r < -lim); end
         3'd1: begin r = sa - sb; e.v = (r >= lim) || (r < -lim); end
         3'd2: r = longint'(a & b);
         3'd3: r = longint'(~b);
         3'd4: r = longint'(a | b);
         3'd5: r = longint'(a ^ b);
         3'd6: r = longint'(a << sh);
         3'd7: r = sa >>> sh;
         default: r = 0;
      endcase
      e.res = 64'(r) & mask;
      e.z   = (e.res == 64'd0);
      e.n   = e.res[w-1];
      e.ld  = ld;
      return e;
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(5))
         0:       return 16'h0000;
         1:       return 16'h7FFF;
         2:       return 16'h8000;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one request until accepted (bounded); starts and ends just after a rising edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic ld, input logic ordy);
      bit fired;
      int n;
      fired = 1'b0;
      n = 0;
      in_valid = 1'b1; Ain = a; Bin = b; ALUop = op; ldstat = ld; out_ready = ordy;
      while (!fired && n < 40) begin
         @(negedge clk);
         fired = in_ready;
         if (fired) q.push_back(model(W, 64'(a), 64'(b), op, ld));
         tick();
         n++;
      end
      if (!fired) chk("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      in_valid = 1'b0; out_ready = 1'b1; in_valid8 = 1'b0;
      while ((q.size() != 0 || q8.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      tick();
      chk("drain_left", 64'(q.size() + q8.size()), 64'd0);
   endtask

   // Monitor for the 16-bit instance: in-order compare, stall stability, status tracking
   initial begin
      exp_t        e;
      bit          prev_stall;
      logic [W-1:0] prev_out;
      logic [2:0]  prev_f;
      prev_stall = 1'b0;
      prev_out = '0;
      prev_f = 3'b000;
      forever begin
         @(negedge clk);
         if (reset) begin
            q.delete();
            exp_stat = 3'b000;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_out", 64'(out), 64'(prev_out));
               chk("hold_flags", 64'({Z, V, N}), 64'(prev_f));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_out", 64'(out_valid), 64'd0);
               end else begin
                  e = q.pop_front();
                  chk("out", 64'(out), e.res);
                  chk("flags_zvn", 64'({Z, V, N}), 64'({e.z, e.v, e.n}));
                  chk("stat", 64'(stat), 64'(exp_stat));
                  if (e.ld) exp_stat = {e.z, e.v, e.n};
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = out;
            prev_f = {Z, V, N};
         end
      end
   end

   // Monitor for the 8-bit instance
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            q8.delete();
         end else if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
               chk("unexpected_out8", 64'(out_valid8), 64'd0);
            end else begin
               e = q8.pop_front();
               chk("out8", 64'(out8), e.res);
               chk("flags8_zvn", 64'({Z8, V8, N8}), 64'({e.z, e.v, e.n}));
            end
         end
      end
   end

   initial begin
      logic [15:0] bp_a [3];
      logic [7:0]  a8 [2];
      logic [7:0]  b8 [2];
      exp_t        e8 [2];
      int          idx, n;
      bit          fired;

      checks = 0; errors = 0; exp_stat = 3'b000;
      reset = 1'b1;
      in_valid = 1'b0; Ain = '0; Bin = '0; ALUop = 3'b000; ldstat = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; Ain8 = '0; Bin8 = '0; ALUop8 = 3'b000; ldstat8 = 1'b0; out_ready8 = 1'b1;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_stat", 64'(stat), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(in_ready), 64'd1);
      tick();

      // Overflowing add: latency of two edges, then status load
      send(16'h7FFF, 16'h0001, 3'b000, 1'b1, 1'b1);
      @(negedge clk);
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("add_out", 64'(out), 64'h8000);
      chk("add_zvn", 64'({Z, V, N}), 64'(3'b011));
      tick();
      @(negedge clk);
      chk("add_stat", 64'(stat), 64'(3'b011));
      tick();

      // Back-to-back subtractions, then logic and shifts; none load status
      send(16'h8000, 16'h0001, 3'b001, 1'b0, 1'b1);
      send(16'h000F, 16'h000F, 3'b001, 1'b0, 1'b1);
      send(16'h0002, 16'h0001, 3'b001, 1'b0, 1'b1);
      send(16'h1000, 16'h0001, 3'b010, 1'b0, 1'b1);
      send(16'h1000, 16'h0001, 3'b011, 1'b0, 1'b1);
      send(16'h1000, 16'h0001, 3'b110, 1'b0, 1'b1);
      send(16'h8000, 16'h0004, 3'b111, 1'b0, 1'b1);
      drain(20);
      chk("stat_unchanged", 64'(stat), 64'(3'b011));

      // 8-bit instance: overflow at 8 bits and shift amount masked to 3 bits
      a8[0] = 8'h7F; b8[0] = 8'h01; e8[0] = '{res: 64'h80, z: 1'b0, v: 1'b1, n: 1'b1, ld: 1'b0};
      a8[1] = 8'h81; b8[1] = 8'h0B; e8[1] = '{res: 64'h08, z: 1'b0, v: 1'b0, n: 1'b0, ld: 1'b0};
      for (int i = 0; i < 2; i++) begin
         in_valid8 = 1'b1; Ain8 = a8[i]; Bin8 = b8[i]; ALUop8 = (i == 0) ? 3'b000 : 3'b110;
         fired = 1'b0; n = 0;
         while (!fired && n < 20) begin
            @(negedge clk);
            fired = in_ready8;
            if (fired) q8.push_back(e8[i]);
            tick();
            n++;
         end
         if (!fired) chk("send8_timeout", 64'(in_ready8), 64'd1);
      end
      drain(20);

      // Backpressure: three requests offered against five stalled cycles
      bp_a[0] = 16'h0011; bp_a[1] = 16'h0022; bp_a[2] = 16'h0033;
      idx = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; Ain = bp_a[idx]; Bin = 16'h0100; ALUop = 3'b000; ldstat = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(W, 64'(Ain), 64'(Bin), ALUop, ldstat));
            idx++;
         end
         tick();
      end
      chk("bp_accepted", 64'(idx), 64'd2);
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      out_ready = 1'b1;
      n = 0;
      while (idx < 3 && n < 20) begin
         Ain = bp_a[idx];
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(W, 64'(Ain), 64'(Bin), ALUop, ldstat));
            idx++;
         end
         tick();
         n++;
      end
      chk("bp_all_sent", 64'(idx), 64'd3);
      drain(20);

      // Status source then non-status request, then reset with both stages full
      send(16'h7FFF, 16'h0001, 3'b000, 1'b1, 1'b1);
      send(16'h0000, 16'h0000, 3'b100, 1'b0, 1'b1);
      drain(20);
      chk("stat_kept", 64'(stat), 64'(3'b011));
      send(16'h1234, 16'h0001, 3'b000, 1'b1, 1'b0);
      send(16'h5678, 16'h0001, 3'b000, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_stat", 64'(stat), 64'd0);
      chk("midrst_out", 64'(out), 64'd0);
      chk("midrst_zvn", 64'({Z, V, N}), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 64'(in_ready), 64'd1);
      tick();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("no_stale_out", 64'(out_valid), 64'd0);
         tick();
      end

      // Random traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(3) != 0);
         Ain = pick(); Bin = pick(); ALUop = 3'($urandom_range(7));
         ldstat = ($urandom_range(1) == 1);
         out_ready = ($urandom_range(3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) q.push_back(model(W, 64'(Ain), 64'(Bin), ALUop, ldstat));
         tick();
      end
      drain(40);
      chk("final_stat", 64'(stat), 64'(exp_stat));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
